// File: rtl/led_breather.sv
// led_breather: PWM LED driver whose duty ramps up and down by STEP once per PWM period
// when an update strobe (TICK) has been seen. Duty changes only at the period boundary.
// Define LED_BREATHER_HOLD_EN to dwell HOLD_TICKS extra updates at the peak and trough.
module led_breather #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned STEP       = 1,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             TICK,
  output logic             LED,
  output logic [WIDTH-1:0] LEVEL,
  output logic             RISING,
  output logic             PERIOD
);

  localparam logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

  // Elaboration-time parameter sanity.
  if (STEP == 0 || STEP > (2 ** WIDTH) - 1) begin : g_bad_step
    $error("STEP must be in 1..2**WIDTH-1");
  end
  if (HOLD_TICKS == 0) begin : g_bad_hold
    $error("HOLD_TICKS must be >= 1");
  end

`ifdef LED_BREATHER_HOLD_EN
  typedef enum logic [1:0] {StUp, StDown, StHoldHi, StHoldLo} state_e;
  localparam state_e PeakState   = StHoldHi;
  localparam state_e TroughState = StHoldLo;

  localparam int unsigned      HoldW     = $clog2(HOLD_TICKS + 1);
  localparam logic [HoldW-1:0] HOLD_LAST = HoldW'(HOLD_TICKS);

  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
`else
  typedef enum logic {StUp, StDown} state_e;
  localparam state_e PeakState   = StDown;
  localparam state_e TroughState = StUp;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic             rising_q, rising_d;

  logic [WIDTH-1:0] pwm_cnt_q;
  logic             pend_q;
  logic             led_q;
  logic             period_q;

  logic             boundary;
  logic             apply;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH-1:0] up_level;
  logic [WIDTH-1:0] down_level;

  assign boundary = EN && (pwm_cnt_q == MAX);
  // A tick on the boundary cycle itself counts, so it does not wait a full period.
  assign apply    = boundary && (pend_q || TICK);

  // Saturating step candidates; the sum is one bit wider so it cannot wrap.
  assign up_sum     = {1'b0, level_q} + STEP_EXT;
  assign up_level   = (up_sum > {1'b0, MAX}) ? MAX : up_sum[WIDTH-1:0];
  assign down_level = (level_q > STEP_W) ? (level_q - STEP_W) : '0;

  // PWM counter, update-pending flag and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pwm_cnt_q <= '0;
      pend_q    <= 1'b0;
      led_q     <= 1'b0;
      period_q  <= 1'b0;
    end else begin
      if (EN) begin
        pwm_cnt_q <= pwm_cnt_q + 1'b1;
      end
      if (apply) begin
        pend_q <= 1'b0;
      end else if (EN && TICK) begin
        pend_q <= 1'b1;
      end
      led_q    <= EN && (pwm_cnt_q < level_q);
      period_q <= boundary;
    end
  end

  // State register: direction state, brightness level, dwell counter and direction flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StUp;
      level_q    <= '0;
      rising_q   <= 1'b1;
`ifdef LED_BREATHER_HOLD_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      rising_q   <= rising_d;
`ifdef LED_BREATHER_HOLD_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  // Next-state: everything advances only on an applied update.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
`ifdef LED_BREATHER_HOLD_EN
    hold_cnt_d = hold_cnt_q;
`endif
    if (apply) begin
      unique case (state_q)
        StUp: begin
          level_d = up_level;
          if (up_level == MAX) state_d = PeakState;
        end
        StDown: begin
          level_d = down_level;
          if (down_level == '0) state_d = TroughState;
        end
`ifdef LED_BREATHER_HOLD_EN
        // The final dwell update takes the step, exactly as the opposite ramp state would.
        StHoldHi: begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            level_d    = down_level;
            state_d    = (down_level == '0) ? StHoldLo : StDown;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        StHoldLo: begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            level_d    = up_level;
            state_d    = (up_level == MAX) ? StHoldHi : StUp;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
`endif
      endcase
    end
  end

  // Output decode from the next state so RISING can be registered alongside the state.
  always_comb begin
    rising_d = 1'b0;
`ifdef LED_BREATHER_HOLD_EN
    rising_d = (state_d == StUp) || (state_d == StHoldLo);
`else
    rising_d = (state_d == StUp);
`endif
  end

  assign LED    = led_q;
  assign LEVEL  = level_q;
  assign RISING = rising_q;
  assign PERIOD = period_q;

endmodule

// File: tb/tb_led_breather.sv
// Scoreboard bench for led_breather: two 4-bit instances (STEP=1 and STEP=6).
// Stimulus runs whole PWM periods and pushes the expected post-boundary level, direction and
// the LED pattern of the period just played; a monitor pops and compares on every PERIOD.
module tb_led_breather;

  typedef struct packed {
    logic [3:0]  level;
    logic        rising;
    logic [15:0] mask;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst    [2];
  logic       en     [2];
  logic       tick   [2];
  logic       led    [2];
  logic [3:0] level  [2];
  logic       rising [2];
  logic       period [2];

  exp_t q0[$];
  exp_t q1[$];

  int n_vec = 0;
  int n_err = 0;

  logic [3:0]  cur_level [2];
  logic [15:0] mon_mask  [2];
  int          mon_pos   [2];
  int          mon_since [2];
  bit          mon_have  [2];

  always #5 clk = ~clk;

  led_breather #(.WIDTH(4), .STEP(1), .HOLD_TICKS(2)) u_a (
    .CLK(clk), .RESET(rst[0]), .EN(en[0]), .TICK(tick[0]),
    .LED(led[0]), .LEVEL(level[0]), .RISING(rising[0]), .PERIOD(period[0])
  );

  led_breather #(.WIDTH(4), .STEP(6), .HOLD_TICKS(2)) u_b (
    .CLK(clk), .RESET(rst[1]), .EN(en[1]), .TICK(tick[1]),
    .LED(led[1]), .LEVEL(level[1]), .RISING(rising[1]), .PERIOD(period[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor step for instance i, sampled 1 time unit after each rising edge.
  task automatic mon_step(input int i);
    exp_t e;
    bit   empty;
    if (rst[i]) begin
      mon_pos[i]   = 0;
      mon_mask[i]  = '0;
      mon_since[i] = 0;
      mon_have[i]  = 1'b1;
    end else begin
      if (en[i]) begin
        if (mon_pos[i] < 16) mon_mask[i][mon_pos[i]] = led[i];
        mon_pos[i]++;
        mon_since[i]++;
      end
      if (period[i]) begin
        empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
          n_vec++;
          n_err++;
          $display("FAIL dut%0d_unexpected_period: got level %0d, expected no update", i, level[i]);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("dut%0d_level", i), level[i], e.level);
          chk($sformatf("dut%0d_rising", i), rising[i], e.rising);
          chk($sformatf("dut%0d_led_pattern", i), mon_mask[i], e.mask);
          if (mon_have[i]) chk($sformatf("dut%0d_period_gap", i), mon_since[i], 16);
        end
        mon_pos[i]   = 0;
        mon_mask[i]  = '0;
        mon_since[i] = 0;
        mon_have[i]  = 1'b1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mon_pos[i] = 0; mon_mask[i] = '0; mon_since[i] = 0; mon_have[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) mon_step(i);
    end
  end

  // Hold reset for n edges (optionally ticking), check reset values, then release.
  // Tasks start and end on a falling edge; inputs driven there are used by the next edge.
  task automatic do_reset(input int i, input int n, input logic t);
    rst[i]  = 1'b1;
    tick[i] = t;
    en[i]   = 1'b1;
    repeat (n) @(negedge clk);
    chk($sformatf("dut%0d_rst_led", i), led[i], 0);
    chk($sformatf("dut%0d_rst_level", i), level[i], 0);
    chk($sformatf("dut%0d_rst_rising", i), rising[i], 1);
    chk($sformatf("dut%0d_rst_period", i), period[i], 0);
    rst[i]       = 1'b0;
    tick[i]      = 1'b0;
    cur_level[i] = 4'd0;
  endtask

  // One full PWM period. tmask bit j is TICK for the j-th edge (bit 15 = boundary edge).
  // Optionally EN drops for gap_len cycles before edge gap_at, with TICK high throughout.
  task automatic run_period(input int i, input logic [15:0] tmask, input logic [3:0] lvl,
                            input logic rise, input int gap_at, input int gap_len);
    exp_t       e;
    logic [3:0] held;
    held    = cur_level[i];
    e.level  = lvl;
    e.rising = rise;
    e.mask   = (16'd1 << held) - 16'd1;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    cur_level[i] = lvl;
    for (int j = 0; j < 16; j++) begin
      if (j == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          en[i]   = 1'b0;
          tick[i] = 1'b1;
          @(negedge clk);
          if (g == 0) begin
            chk($sformatf("dut%0d_en0_led", i), led[i], 0);
            chk($sformatf("dut%0d_en0_level", i), level[i], held);
            chk($sformatf("dut%0d_en0_period", i), period[i], 0);
          end
        end
      end
      en[i]   = 1'b1;
      tick[i] = tmask[j];
      @(negedge clk);
    end
  endtask

  initial begin
    rst[0] = 1'b1; rst[1] = 1'b1;
    en[0]  = 1'b1; en[1]  = 1'b1;
    tick[0] = 1'b0; tick[1] = 1'b0;
    cur_level[0] = 4'd0; cur_level[1] = 4'd0;
    @(negedge clk);

    // Instance A (STEP=1): reset values, then a full ramp with TICK held high.
    do_reset(0, 2, 1'b0);
    for (int v = 1; v <= 15; v++) run_period(0, 16'hFFFF, 4'(v), v != 15, -1, 0);
`ifdef LED_BREATHER_HOLD_EN
    run_period(0, 16'hFFFF, 4'd15, 1'b0, -1, 0);
    run_period(0, 16'hFFFF, 4'd15, 1'b0, -1, 0);
`endif
    for (int v = 14; v >= 0; v--) run_period(0, 16'hFFFF, 4'(v), v == 0, -1, 0);
`ifdef LED_BREATHER_HOLD_EN
    run_period(0, 16'hFFFF, 4'd0, 1'b1, -1, 0);
    run_period(0, 16'hFFFF, 4'd0, 1'b1, -1, 0);
`endif
    run_period(0, 16'hFFFF, 4'd1, 1'b1, -1, 0);

    // Up to 5, then stop ticking: duty 5/16 checked by the LED pattern.
    for (int v = 2; v <= 5; v++) run_period(0, 16'hFFFF, 4'(v), 1'b1, -1, 0);
    run_period(0, 16'h0000, 4'd5, 1'b1, -1, 0);
    run_period(0, 16'h0000, 4'd5, 1'b1, -1, 0);

    // Two ticks in one period collapse to one step; a boundary-only tick applies at once.
    run_period(0, 16'h0108, 4'd6, 1'b1, -1, 0);
    run_period(0, 16'h8000, 4'd7, 1'b1, -1, 0);

    // EN dropped mid-period with TICK high: nothing moves, ticks are ignored.
    run_period(0, 16'h0000, 4'd7, 1'b1, 6, 4);

    // Reset mid-period at level 7 with TICK high; counter restarts from 0 on release.
    repeat (5) begin
      tick[0] = 1'b0;
      @(negedge clk);
    end
    do_reset(0, 2, 1'b1);
    run_period(0, 16'hFFFF, 4'd1, 1'b1, -1, 0);
    run_period(0, 16'h0000, 4'd1, 1'b1, -1, 0);
    rst[0] = 1'b1;

    // Instance B (STEP=6): saturating steps at both ends.
    do_reset(1, 2, 1'b0);
    run_period(1, 16'hFFFF, 4'd6, 1'b1, -1, 0);
    run_period(1, 16'hFFFF, 4'd12, 1'b1, -1, 0);
    run_period(1, 16'hFFFF, 4'd15, 1'b0, -1, 0);
`ifdef LED_BREATHER_HOLD_EN
    run_period(1, 16'hFFFF, 4'd15, 1'b0, -1, 0);
    run_period(1, 16'hFFFF, 4'd15, 1'b0, -1, 0);
`endif
    run_period(1, 16'hFFFF, 4'd9, 1'b0, -1, 0);
    run_period(1, 16'hFFFF, 4'd3, 1'b0, -1, 0);
    run_period(1, 16'hFFFF, 4'd0, 1'b1, -1, 0);
`ifdef LED_BREATHER_HOLD_EN
    run_period(1, 16'hFFFF, 4'd0, 1'b1, -1, 0);
    run_period(1, 16'hFFFF, 4'd0, 1'b1, -1, 0);
`endif
    run_period(1, 16'hFFFF, 4'd6, 1'b1, -1, 0);
    rst[1] = 1'b1;

    repeat (3) @(negedge clk);
    chk("dut0_queue_drained", q0.size(), 0);
    chk("dut1_queue_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
